fetch_unit: RTL and testbench

- Instruction-fetch front end of the single-cycle RISC-V core.
- Sits directly upstream of the instruction memory. It owns the program counter and drives the memory's word-aligned byte address.
- Captures the combinational instruction word into a small prefetch queue, then presents {pc, instr} to decode over a valid/ready handshake.
- Handles control-flow redirects from execute by flushing the queue and reloading the PC.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the instruction memory, buffers fetched words for decode.
// Optional FETCH_STATS_EN adds fetched/stall event counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        misalign_err
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_stall
`endif
);

    localparam int               PTR_W = $clog2(DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [31:0]      NOP   = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      q_pc    [DEPTH];
    logic [31:0]      q_instr [DEPTH];
    logic             pop;
    logic             push;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign push      = !redirect_valid && ((count < FULL) || pop);

    assign imem_addr = fetch_pc;
    assign out_pc    = q_pc[rd_ptr];
    assign out_instr = q_instr[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                // Flush: any entry popped this cycle is considered consumed.
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= NOP;
            end
        end else if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= imem_instr;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
        end else begin
            if (push) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if ((count == FULL) && !pop && !redirect_valid) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized redirect/ready traffic
// compared against a queue-based reference model. Handles FETCH_STATS_EN builds too.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_addr, imem_instr, imem_addr2, imem_instr2;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_valid2;
    logic [31:0] out_pc, out_instr, out_pc2, out_instr2;
    logic        misalign_err, misalign_err2;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_stall, stat_fetched2, stat_stall2;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0] mq[$];
    logic [31:0] m_fpc;
    logic        m_mis;
    logic [31:0] m_fetched, m_stall;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0: return 32'h0050_0093;
            32'h4: return 32'h0060_0113;
            32'h8: return 32'h0020_81B3;
            default: return a ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign imem_instr  = mem_f(imem_addr);
    assign imem_instr2 = mem_f(imem_addr2);

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .misalign_err(misalign_err)
`ifdef FETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_stall(stat_stall)
`endif
    );

    fetch_unit #(.RESET_PC(RPC2), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid2), .out_ready(out_ready), .out_pc(out_pc2), .out_instr(out_instr2),
        .misalign_err(misalign_err2)
`ifdef FETCH_STATS_EN
        , .stat_fetched(stat_fetched2), .stat_stall(stat_stall2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc     = RPC;
        m_mis     = 1'b0;
        m_fetched = '0;
        m_stall   = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit pop, push;
        pop = (mq.size() != 0) && out_ready;
        if (!redirect_valid && mq.size() == DEPTH && !pop) m_stall++;
        if (redirect_valid) begin
            mq.delete();
            m_fpc = {redirect_pc[31:2], 2'b00};
        end else begin
            push = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_fpc, mem_f(m_fpc)});
                m_fpc = m_fpc + 32'd4;
                m_fetched++;
            end
        end
        m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
    endtask

    task automatic check_all();
        chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0][63:32]);
            chk("out_instr", out_instr, mq[0][31:0]);
        end
        chk("imem_addr", imem_addr, m_fpc);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
`ifdef FETCH_STATS_EN
        chk("stat_fetched", stat_fetched, m_fetched);
        chk("stat_stall", stat_stall, m_stall);
`endif
    endtask

    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Assert reset between edges, check immediate effect, hold across an edge, release.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, NOP);
        chk("rst_addr2", imem_addr2, RPC2);
        chk("rst_valid2", {31'b0, out_valid2}, 32'h0);
        @(posedge clk);
        #1;
        check_all();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        rst_n          = 1'b1;
    endtask

    initial begin
        do_reset();

        // Streaming with ready high; dut2 exercises the PC wrap from the top of memory.
        cycle(1'b0, 32'h0, 1'b1);
        chk("wrap_pc0", out_pc2, 32'hFFFF_FFF8);
        cycle(1'b0, 32'h0, 1'b1);
        chk("wrap_pc1", out_pc2, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b1);
        chk("wrap_pc2", out_pc2, 32'h0000_0000);
        chk("wrap_valid", {31'b0, out_valid2}, 32'h1);

        // Back-pressure after a fresh reset, then release.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_pc", out_pc, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        // Redirect with a full queue, then a misaligned redirect.
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h40, 1'b0);
        chk("redir_valid", {31'b0, out_valid}, 32'h0);
        chk("redir_addr", imem_addr, 32'h40);
        cycle(1'b0, 32'h0, 1'b0);
        chk("redir_pc", out_pc, 32'h40);
        cycle(1'b1, 32'h42, 1'b1);
        chk("mis_pulse", {31'b0, misalign_err}, 32'h1);
        chk("mis_addr", imem_addr, 32'h40);
        cycle(1'b0, 32'h0, 1'b1);
        chk("mis_clear", {31'b0, misalign_err}, 32'h0);
        cycle(1'b1, 32'h100, 1'b1);
        cycle(1'b1, 32'h203, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 7) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                              : ($urandom & 32'h0000_03FF);
            cycle(rv, rpc, $urandom_range(0, 2) != 0);
        end

        // Reset mid-stream, then restart.
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, $urandom_range(0, 1) == 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
